load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Initiator-side companion to the core's word-addressed data memory. It accepts one byte-addressed load or store from the execute stage at a time and drives the memory's read/write strobes, word address and write data, then captures read data. It performs byte/halfword extraction with sign or zero extension on loads, and read-modify-write for sub-word stores, because the memory only holds whole words. It returns a single response per request, carrying data or an error flag.

Parameters:
WIDTH, 32, data/word width in bits; only 32 is supported.
DEPTH, 512, memory depth in words; word indices at or above DEPTH are out of range.
MEM_LAT, 2, cycles a memory strobe is held before read data is valid or a write has completed; legal range 1..15.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle, able to accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data; the low bytes are used for sub-word stores
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal-size request
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  $clog2(DEPTH)  word index, equal to req_addr[$clog2(DEPTH)+1:2]
mem_wdata  out  32  word to write
mem_rdata  in  32  word read

Behaviour:
- Reset, asynchronous: FSM goes to IDLE. req_ready=1. resp_valid, resp_err, mem_read and mem_write go to 0. resp_rdata, mem_addr and mem_wdata go to 0. A reset in mid-operation drops the strobes immediately and no response is produced.
- Handshake: a request is accepted in cycle T when req_valid && req_ready. All request fields are latched at T. req_ready=0 from T+1 until the cycle after resp_valid. Only one request is outstanding at a time.
- Checks at acceptance:
  - Error if size==11.
  - Error if half with addr[0]!=0.
  - Error if word with addr[1:0]!=0.
  - Error if word index >= DEPTH.
  - On error: no strobe is asserted, resp_valid=1 and resp_err=1 at T+1.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP. A down-counter of width 4 is loaded with MEM_LAT-1 on entry to each strobe state.
- Load:
  - IDLE -> RD. mem_read=1 for cycles T+1..T+MEM_LAT.
  - mem_rdata is sampled on the last RD edge.
  - resp_valid at T+MEM_LAT+1.
- Word store:
  - IDLE -> WR. mem_write=1 and mem_wdata=req_wdata for MEM_LAT cycles.
  - resp at T+MEM_LAT+1.
- Byte/half store:
  - IDLE -> RMW_RD for MEM_LAT cycles, capturing the old word.
  - RMW_WR for MEM_LAT cycles, writing the merged word: only the lanes selected by addr[1:0] and size are replaced from the low bytes of req_wdata.
  - resp at T+2*MEM_LAT+1.
- mem_read and mem_write are never high in the same cycle. mem_addr is stable throughout all strobe cycles.
- Load extraction:
  - byte = word >> (8*addr[1:0]) [7:0]
  - half = word >> (16*addr[1]) [15:0]
  - The result is extended per req_unsigned; words pass through unchanged.
- RESP lasts one cycle: resp_valid=1, then the FSM returns to IDLE and req_ready=1 the next cycle. resp_rdata holds its value until the next response.
- A req_valid that arrives while busy is ignored; the requester must hold it.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state typedef lsu_state_t
  - the check function misaligned(size, addr_lo)
- One combinational sub-module, lsu_align, is natural. It performs store byte-lane merge (old word, wdata, size, offset -> new word) and load extract/extend (word, size, offset, unsigned -> result). This keeps the FSM file small and lets the lane logic be unit-tested on its own.

Test Plan:
- Setup for all scenarios: model memory with mem[k]=k, except mem[3]=0x80F0_7F81, MEM_LAT=2.
- Load word, addr 0x8 -> mem_read high T+1..T+2, mem_addr=2. resp_valid at T+3 with rdata=0x0000_0002, err=0.
- Byte and half loads from word 3:
  - lb addr 0xC -> 0xFFFF_FF81.
  - lbu addr 0xD -> 0x0000_007F.
  - lh addr 0xE -> 0xFFFF_80F0.
  - lhu addr 0xE -> 0x0000_80F0.
- Store byte 0xAB at addr 0x15 (old word 0x0000_0005) -> read for 2 cycles, then mem_write with mem_wdata=0x0000_AB05 for 2 cycles. resp at T+5, then a reload of word 5 returns 0x0000_AB05.
- Errors, each giving resp_err=1 at T+1 with no strobe:
  - lw addr 0x6
  - sh addr 0x3
  - size 11
  - addr 0x800 (word 512)
- Back-to-back requests with req_valid held high -> second acceptance occurs exactly one cycle after the first resp_valid, and req_ready=0 throughout the first operation.
- rst_n pulled low during the RMW_WR phase of a store -> mem_write drops asynchronously, no resp_valid, req_ready=1 after release, and the next load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment check used at request acceptance.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_t;

  // Also flags the illegal size code so one call covers every encoding.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: merges sub-word store data into an old word and extracts
// plus sign/zero-extends sub-word load data from a read word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rword,
  input  logic [1:0]       size,
  input  logic [1:0]       offset,
  input  logic             uns,
  output logic [WIDTH-1:0] merged,
  output logic [WIDTH-1:0] rdata
);

  logic [4:0]       shamt;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shamt   = (size == SZ_HALF) ? {offset[1], 4'b0000} : {offset, 3'b000};
    mask    = '1;
    rdata   = rword;
    shifted = rword >> shamt;
    case (size)
      SZ_BYTE: begin
        mask  = WIDTH'(8'hFF) << shamt;
        rdata = {{(WIDTH-8){~uns & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        mask  = WIDTH'(16'hFFFF) << shamt;
        rdata = {{(WIDTH-16){~uns & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        mask  = '1;
        rdata = rword;
      end
    endcase
    merged = (old_word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one byte-addressed request at a time against a word memory,
// with read-modify-write for sub-word stores and extension on loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 512,
  parameter int MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_rdata,
  output logic                     resp_err,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  lsu_state_t       state;
  logic [3:0]       cnt;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             uns_q;
  logic             err_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] ld_data;
  logic             req_err;

  assign req_err = misaligned(req_size, req_addr[1:0]) ||
                   (req_addr[31:2] >= 30'(DEPTH));

  // Strobes and handshake decode straight from state so reset kills them at once.
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign mem_read   = (state == ST_RD) || (state == ST_RMW_RD);
  assign mem_write  = (state == ST_WR) || (state == ST_RMW_WR);

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .rword    (mem_rdata),
    .size     (size_q),
    .offset   (off_q),
    .uns      (uns_q),
    .merged   (merged),
    .rdata    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      size_q     <= '0;
      off_q      <= '0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            off_q   <= req_addr[1:0];
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            cnt     <= LAT_M1;
            if (req_err) begin
              resp_rdata <= '0;
              state      <= ST_RESP;
            end else begin
              mem_addr <= req_addr[AW+1:2];
              if (!req_we) begin
                state <= ST_RD;
              end else if (req_size == SZ_WORD) begin
                mem_wdata <= req_wdata;
                state     <= ST_WR;
              end else begin
                state <= ST_RMW_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (cnt == '0) begin
            resp_rdata <= ld_data;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RMW_RD: begin
          if (cnt == '0) begin
            mem_wdata <= merged;
            cnt       <= LAT_M1;
            state     <= ST_RMW_WR;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WR, ST_RMW_WR: begin
          if (cnt == '0) begin
            resp_rdata <= '0;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
